// File: rtl/instr_encoder_loader_if.sv
// ---------------------------------------------------------------------------
// instr_encoder_loader_if
//   Bundles the two buses of the instruction encoder/loader:
//     - field-tuple input stream from the host/boot side
//       (in_valid, in_ready, in_last, in_op, in_rd, in_rs, in_imm)
//     - program-memory write port (pm_we, pm_addr, pm_wdata)
//   Modports:
//     master : host / boot side (drives tuples, observes memory writes)
//     slave  : the encoder/loader itself
//
//   Handshake: a tuple transfers on a rising clk edge where in_valid and
//   in_ready are both 1. The host holds the tuple fields stable while
//   in_valid=1 and may not withdraw them until the transfer happens;
//   in_ready depends only on the loader's state, never on in_valid.
// ---------------------------------------------------------------------------
interface instr_encoder_loader_if #(
    parameter int n     = 8,
    parameter int Rbits = 3,
    parameter int Psize = 6
);
    localparam int Isize = 3 + 2 * Rbits + n;

    logic             in_valid;
    logic             in_ready;
    logic             in_last;
    logic [2:0]       in_op;
    logic [Rbits-1:0] in_rd;
    logic [Rbits-1:0] in_rs;
    logic [n-1:0]     in_imm;

    logic             pm_we;
    logic [Psize-1:0] pm_addr;
    logic [Isize-1:0] pm_wdata;

    modport master (
        output in_valid, in_last, in_op, in_rd, in_rs, in_imm,
        input  in_ready, pm_we, pm_addr, pm_wdata
    );

    modport slave (
        input  in_valid, in_last, in_op, in_rd, in_rs, in_imm,
        output in_ready, pm_we, pm_addr, pm_wdata
    );
endinterface

// File: rtl/instr_encoder_loader.sv
// ---------------------------------------------------------------------------
// instr_encoder_loader
//   Encodes picoMIPS field tuples {op, rd, rs, imm} into instruction words
//   and writes them to consecutive program-memory addresses. The CPU is held
//   in reset (cpu_run=0) until a load session has completed.
//
//   Ports:
//     clk        in   rising-edge clock
//     nReset     in   asynchronous active-low reset
//     start      in   begin a load session (honoured in IDLE and DONE only)
//     bus        --   tuple stream + program-memory write port (slave side)
//     word_count out  words written in the current session
//     err_op     out  sticky: tuple with illegal opcode (011/111) received
//     err_full   out  sticky: tuple offered after memory filled up
//     cpu_run    out  CPU release, high in DONE only
//     state_dbg  out  current FSM state (IDLE=0 LOAD=1 WRITE=2 DONE=3)
// ---------------------------------------------------------------------------
module instr_encoder_loader #(
    parameter int n     = 8,
    parameter int Rbits = 3,
    parameter int Psize = 6
) (
    input  logic                 clk,
    input  logic                 nReset,
    input  logic                 start,
    instr_encoder_loader_if.slave bus,
    output logic [Psize:0]       word_count,
    output logic                 err_op,
    output logic                 err_full,
    output logic                 cpu_run,
    output logic [1:0]           state_dbg
);
    localparam int Isize = 3 + 2 * Rbits + n;

    localparam logic [Psize-1:0] ADDR_MAX  = {Psize{1'b1}};
    localparam logic [Psize-1:0] ADDR_ONE  = {{(Psize-1){1'b0}}, 1'b1};
    localparam logic [Psize:0]   COUNT_ONE = {{Psize{1'b0}}, 1'b1};
    localparam logic [Psize:0]   DEPTH     = {1'b1, {Psize{1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           state, state_nx;

    logic [Psize-1:0] next_addr;   // address the next accepted word goes to
    logic [Psize-1:0] addr_q;      // address presented with the pending write
    logic [Isize-1:0] wdata_q;
    logic             last_q;

    logic             op_legal;
    logic [Rbits-1:0] enc_rd, enc_rs;
    logic [n-1:0]     enc_imm;

    logic             ready_c, we_c, run_c;
    logic             take, new_session, set_err_op, set_err_full;

    // Canonical encoding: fields an opcode does not use are forced to zero.
    always_comb begin
        op_legal = (bus.in_op != 3'b011) && (bus.in_op != 3'b111);
        enc_rd   = bus.in_rd;
        enc_rs   = bus.in_rs;
        enc_imm  = bus.in_imm;
        case (bus.in_op)
            3'b000:         enc_rs  = '0;                    // LD
            3'b001, 3'b010: begin enc_rd = '0; enc_rs = '0; end // BNE/BEQ
            3'b100, 3'b110: enc_imm = '0;                    // ADD/MUL
            default: ;                                       // ADDI keeps all
        endcase
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) state <= S_IDLE;
        else         state <= state_nx;
    end

    always_comb begin
        state_nx     = state;
        ready_c      = 1'b0;
        we_c         = 1'b0;
        run_c        = 1'b0;
        take         = 1'b0;
        new_session  = 1'b0;
        set_err_op   = 1'b0;
        set_err_full = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nx    = S_LOAD;
                    new_session = 1'b1;
                end
            end
            S_LOAD: begin
                ready_c = 1'b1;
                if (bus.in_valid) begin
                    if (op_legal) begin
                        take     = 1'b1;
                        state_nx = S_WRITE;
                    end else begin
                        // Bad tuple is dropped; a trailing bad tuple still ends the program.
                        set_err_op = 1'b1;
                        if (bus.in_last) state_nx = S_DONE;
                    end
                end
            end
            S_WRITE: begin
                we_c = 1'b1;
                if (last_q || addr_q == ADDR_MAX) state_nx = S_DONE;
                else                              state_nx = S_LOAD;
            end
            S_DONE: begin
                run_c = 1'b1;
                if (start) begin
                    state_nx    = S_LOAD;
                    new_session = 1'b1;
                end else if (bus.in_valid && word_count == DEPTH) begin
                    set_err_full = 1'b1;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Write address/word are captured at the handshake and held until the
    // next one, so they never move while pm_we is low.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            next_addr  <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            last_q     <= 1'b0;
            word_count <= '0;
            err_op     <= 1'b0;
            err_full   <= 1'b0;
        end else begin
            if (new_session) begin
                next_addr  <= '0;
                word_count <= '0;
                err_op     <= 1'b0;
                err_full   <= 1'b0;
            end
            if (take) begin
                addr_q  <= next_addr;
                wdata_q <= {bus.in_op, enc_rd, enc_rs, enc_imm};
                last_q  <= bus.in_last;
            end
            if (we_c) begin
                next_addr  <= next_addr + ADDR_ONE;
                word_count <= word_count + COUNT_ONE;
            end
            if (set_err_op)   err_op   <= 1'b1;
            if (set_err_full) err_full <= 1'b1;
        end
    end

    // Strobes decode straight from the state register so an async reset
    // removes them immediately.
    assign bus.in_ready = ready_c;
    assign bus.pm_we    = we_c;
    assign bus.pm_addr  = addr_q;
    assign bus.pm_wdata = wdata_q;
    assign cpu_run      = run_c;
    assign state_dbg    = state;
endmodule

// File: tb/tb_instr_encoder_loader.sv
module tb_instr_encoder_loader;
  localparam int N     = 8;
  localparam int RB    = 3;
  localparam int PS    = 6;
  localparam int IS    = 3 + 2 * RB + N;
  localparam int DEPTH = 64;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic nreset_drv = 1'b0;
  logic start = 1'b0;
  logic [PS:0] word_count;
  logic err_op, err_full, cpu_run;
  logic [1:0] state_dbg;

  always #5 clk = ~clk;

  instr_encoder_loader_if #(.n(N), .Rbits(RB), .Psize(PS)) bus ();

  instr_encoder_loader #(.n(N), .Rbits(RB), .Psize(PS)) dut (
    .clk       (clk),
    .nReset    (nreset_drv),
    .start     (start),
    .bus       (bus),
    .word_count(word_count),
    .err_op    (err_op),
    .err_full  (err_full),
    .cpu_run   (cpu_run),
    .state_dbg (state_dbg)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [PS+IS-1:0] exp_q[$];

  // reference session model
  int m_addr = 0;
  bit m_err_op = 0;
  bit m_done = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Instruction word from the opcode's field-usage rules.
  function automatic logic [IS-1:0] ref_word(input int op, input int rd, input int rs, input int imm);
    bit use_rd, use_rs, use_imm;
    use_rd  = !(op == 1 || op == 2);
    use_rs  = (op == 4 || op == 5 || op == 6);
    use_imm = (op == 0 || op == 1 || op == 2 || op == 5);
    return IS'(op * 16384 + (use_rd ? rd : 0) * 2048 + (use_rs ? rs : 0) * 256 + (use_imm ? imm : 0));
  endfunction

  // Every write on the memory port must match the head of the expected queue.
  always @(negedge clk) begin : write_monitor
    logic [PS+IS-1:0] e;
    if (bus.pm_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", 32'({bus.pm_addr, bus.pm_wdata}), 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("pm_write", 32'({bus.pm_addr, bus.pm_wdata}), 32'(e));
      end
    end
  end

  // ---------------- driver tasks (entered at a negedge) ----------------
  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    m_addr = 0;
    m_err_op = 0;
    m_done = 0;
    check("start_run_low", 32'(cpu_run), 32'd0);
    check("start_count_clr", 32'(word_count), 32'd0);
    check("start_err_clr", 32'({err_op, err_full}), 32'd0);
  endtask

  // golden < 0 -> expected word comes from ref_word
  task automatic send_tuple(input int op, input int rd, input int rs, input int imm,
                            input bit last, input int golden);
    bit ok;
    bit legal;
    logic [IS-1:0] word;
    legal = (op != 3) && (op != 7);
    bus.in_op    = 3'(op);
    bus.in_rd    = 3'(rd);
    bus.in_rs    = 3'(rs);
    bus.in_imm   = 8'(imm);
    bus.in_last  = last;
    bus.in_valid = 1'b1;
    ok = 0;
    for (int i = 0; i < 8; i++) begin
      if (bus.in_ready === 1'b1) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    check("in_ready_wait", 32'(ok), 32'd1);
    if (!ok) begin
      bus.in_valid = 1'b0;
      return;
    end
    if (legal) begin
      word = (golden >= 0) ? IS'(golden) : ref_word(op, rd, rs, imm);
      exp_q.push_back({PS'(m_addr), word});
      m_addr++;
      if (last || m_addr == DEPTH) m_done = 1;
    end else begin
      m_err_op = 1;
      if (last) m_done = 1;
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    @(negedge clk);
    check("we_latency", 32'(bus.pm_we), 32'(legal));
    @(negedge clk);
    check("we_one_cycle", 32'(bus.pm_we), 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  int legal_ops[6] = '{0, 1, 2, 4, 5, 6};

  initial begin
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.in_op    = '0;
    bus.in_rd    = '0;
    bus.in_rs    = '0;
    bus.in_imm   = '0;

    // reset state
    #3;
    check("rst_we", 32'(bus.pm_we), 32'd0);
    check("rst_ready", 32'(bus.in_ready), 32'd0);
    check("rst_run", 32'(cpu_run), 32'd0);
    check("rst_count", 32'(word_count), 32'd0);
    check("rst_errs", 32'({err_op, err_full}), 32'd0);
    check("rst_addr_data", 32'({bus.pm_addr, bus.pm_wdata}), 32'd0);
    check("rst_state", 32'(state_dbg), 32'd0);
    @(negedge clk);
    nreset_drv = 1'b1;
    @(negedge clk);
    check("idle_ready", 32'(bus.in_ready), 32'd0);

    // 1: ADD r1,r2 / ADDI r1,5 / MUL r1,r3 (last)
    pulse_start();
    send_tuple(4, 1, 2, 8'h77, 0, 17'b100_001_010_00000000);
    send_tuple(5, 1, 0, 5,     0, 17'b101_001_000_00000101);
    send_tuple(6, 1, 3, 8'h12, 1, 17'b110_001_011_00000000);
    check("t1_count", 32'(word_count), 32'd3);
    check("t1_run", 32'(cpu_run), 32'd1);
    check("t1_err_op", 32'(err_op), 32'd0);

    // 2: restart from DONE, BEQ canonical encoding
    pulse_start();
    send_tuple(2, 5, 6, 8'hFE, 1, 17'b010_000_000_11111110);
    check("t2_count", 32'(word_count), 32'd1);
    check("t2_run", 32'(cpu_run), 32'd1);

    // 3: illegal op mid-program, start held during LOAD
    pulse_start();
    start = 1'b1;
    send_tuple(4, 1, 1, 0, 0, -1);
    send_tuple(3, 4, 5, 8'h33, 0, -1);
    start = 1'b0;
    check("t3_err_op_set", 32'(err_op), 32'd1);
    send_tuple(0, 2, 5, 7, 1, 17'b000_010_000_00000111);
    check("t3_count", 32'(word_count), 32'd2);
    check("t3_err_op", 32'(err_op), 32'(m_err_op));
    check("t3_run", 32'(cpu_run), 32'(m_done));

    // 4: 64 random legal tuples without in_last fill memory
    pulse_start();
    for (int i = 0; i < DEPTH; i++) begin
      send_tuple(legal_ops[$urandom_range(0, 5)], $urandom_range(0, 7),
                 $urandom_range(0, 7), $urandom_range(0, 255), 0, -1);
    end
    check("t4_count", 32'(word_count), 32'(m_addr));
    check("t4_run", 32'(cpu_run), 32'(m_done));
    check("t4_err_full_pre", 32'(err_full), 32'd0);
    check("t4_65_ready", 32'(bus.in_ready), 32'd0);
    bus.in_op    = 3'b101;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("t4_err_full", 32'(err_full), 32'd1);
    check("t4_count_hold", 32'(word_count), 32'd64);
    check("t4_run_hold", 32'(cpu_run), 32'd1);

    // 5: random mixed session with illegal opcodes
    pulse_start();
    for (int i = 0; i < 20; i++) begin
      send_tuple($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                 $urandom_range(0, 255), (i == 19), -1);
    end
    check("t5_count", 32'(word_count), 32'(m_addr));
    check("t5_err_op", 32'(err_op), 32'(m_err_op));
    check("t5_run", 32'(cpu_run), 32'(m_done));
    check("t5_err_full", 32'(err_full), 32'd0);

    // 6: reset during WRITE
    pulse_start();
    bus.in_op    = 3'b101;
    bus.in_rd    = 3'd3;
    bus.in_rs    = 3'd4;
    bus.in_imm   = 8'd9;
    bus.in_last  = 1'b0;
    bus.in_valid = 1'b1;
    exp_q.push_back({PS'(0), ref_word(5, 3, 4, 9)});
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("t6_in_write", 32'(bus.pm_we), 32'd1);
    #2;
    nreset_drv = 1'b0;
    #1;
    check("t6_we_drop", 32'(bus.pm_we), 32'd0);
    check("t6_run_low", 32'(cpu_run), 32'd0);
    check("t6_state_idle", 32'(state_dbg), 32'd0);
    check("t6_count_clr", 32'(word_count), 32'd0);
    @(negedge clk);
    nreset_drv = 1'b1;
    @(negedge clk);
    check("t6_stay_idle", 32'(state_dbg), 32'd0);
    pulse_start();
    send_tuple(0, 2, 6, 7, 1, -1);
    check("t6_count", 32'(word_count), 32'd1);
    check("t6_run", 32'(cpu_run), 32'd1);

    repeat (3) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, summary not produced");
    $fatal(1, "watchdog expired");
  end
endmodule
